// File: rtl/ex_branch_ctrl_pkg.sv
// Shared definitions for the execute-stage branch/hold controller:
// word type, branch encodings, FSM state codes and the branch-condition helper.
package ex_branch_ctrl_pkg;

  typedef logic [31:0] int32_t;

  localparam logic [1:0] B_NONE = 2'b00;
  localparam logic [1:0] B_ALW  = 2'b01;
  localparam logic [1:0] B_Z    = 2'b10;
  localparam logic [1:0] B_N    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STRD = 2'b01,
    ST_CONV = 2'b10
  } state_e;

  function automatic logic branch_cond(input logic [1:0] b, input logic z, input logic n);
    logic taken;
    taken = 1'b0;
    case (b)
      B_ALW:   taken = 1'b1;
      B_Z:     taken = z;
      B_N:     taken = n;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ex_branch_ctrl.sv
// Execute-stage control: resolves branches against the local condition codes and
// holds the pipeline through multi-cycle strided and convolution instructions.
module ex_branch_ctrl
  import ex_branch_ctrl_pkg::*;
#(
  parameter int unsigned CONV_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rB_data,
  input  logic [1:0]  ex_b,
  input  logic        ex_setcc,
  input  logic [2:0]  ex_strd,
  input  logic        ex_conv_en,
  input  logic [31:0] alu_result,
  input  logic        conv_done,
  output logic        conv_start,
  output logic        stall,
  output logic        b_taken,
  output logic [31:0] b_target,
  output logic        cc_z,
  output logic        cc_n,
  output logic        conv_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(CONV_TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  strd_cnt_q, strd_cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic        cc_z_q, cc_z_d;
  logic        cc_n_q, cc_n_d;
  logic        conv_err_q, conv_err_d;

  logic        stall_c;
  logic        start_c;
  logic        complete_c;
  logic        taken_c;
  int32_t      target_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      strd_cnt_q <= 3'd0;
      wait_q     <= 8'd0;
      cc_z_q     <= 1'b0;
      cc_n_q     <= 1'b0;
      conv_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      strd_cnt_q <= strd_cnt_d;
      wait_q     <= wait_d;
      cc_z_q     <= cc_z_d;
      cc_n_q     <= cc_n_d;
      conv_err_q <= conv_err_d;
    end
  end

  // complete_c marks the single cycle in which the held instruction retires.
  always_comb begin
    state_d    = state_q;
    strd_cnt_d = strd_cnt_q;
    wait_d     = wait_q;
    conv_err_d = conv_err_q;
    stall_c    = 1'b0;
    start_c    = 1'b0;
    complete_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_conv_en) begin
          state_d = ST_CONV;
          start_c = 1'b1;
          stall_c = 1'b1;
          wait_d  = 8'd1;
        end else if (ex_strd != 3'd0) begin
          state_d    = ST_STRD;
          strd_cnt_d = ex_strd - 3'd1;
          stall_c    = 1'b1;
        end else begin
          complete_c = 1'b1;
        end
      end
      ST_STRD: begin
        if (strd_cnt_q == 3'd0) begin
          state_d    = ST_IDLE;
          complete_c = 1'b1;
        end else begin
          strd_cnt_d = strd_cnt_q - 3'd1;
          stall_c    = 1'b1;
        end
      end
      ST_CONV: begin
        // Done takes precedence over a timeout landing on the same cycle.
        if (conv_done) begin
          state_d    = ST_IDLE;
          complete_c = 1'b1;
          wait_d     = 8'd0;
        end else if (wait_q == TIMEOUT_CNT) begin
          state_d    = ST_IDLE;
          complete_c = 1'b1;
          conv_err_d = 1'b1;
          wait_d     = 8'd0;
        end else begin
          wait_d  = wait_q + 8'd1;
          stall_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Branches see the flags as they were before their own setcc update.
  always_comb begin
    cc_z_d = cc_z_q;
    cc_n_d = cc_n_q;
    if (complete_c && ex_setcc) begin
      cc_z_d = (alu_result == 32'd0);
      cc_n_d = alu_result[31];
    end
  end

  assign taken_c    = complete_c & branch_cond(ex_b, cc_z_q, cc_n_q);
  assign target_sum = ex_pc + ex_rB_data;

  // Outputs are forced quiet while reset is held, since the ID/EX fields may not yet be cleared.
  assign conv_start = start_c & ~reset;
  assign stall      = stall_c & ~reset;
  assign b_taken    = taken_c & ~reset;
  assign b_target   = (taken_c && !reset) ? target_sum : 32'd0;
  assign cc_z       = cc_z_q;
  assign cc_n       = cc_n_q;
  assign conv_err   = conv_err_q;

endmodule

// File: tb/tb_ex_branch_ctrl.sv
// Directed bench for ex_branch_ctrl: table of single-cycle branch/CC vectors plus
// hand-written strided, convolution, timeout and reset sequences.
module tb_ex_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_pc, ex_rB_data, alu_result;
  logic [1:0]  ex_b;
  logic        ex_setcc, ex_conv_en, conv_done;
  logic [2:0]  ex_strd;

  logic        conv_start, stall, b_taken, cc_z, cc_n, conv_err;
  logic [31:0] b_target;
  logic        t_conv_start, t_stall, t_b_taken, t_cc_z, t_cc_n, t_conv_err;
  logic [31:0] t_b_target;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ex_branch_ctrl dut (
    .clk(clk), .reset(reset), .ex_pc(ex_pc), .ex_rB_data(ex_rB_data), .ex_b(ex_b),
    .ex_setcc(ex_setcc), .ex_strd(ex_strd), .ex_conv_en(ex_conv_en), .alu_result(alu_result),
    .conv_done(conv_done), .conv_start(conv_start), .stall(stall), .b_taken(b_taken),
    .b_target(b_target), .cc_z(cc_z), .cc_n(cc_n), .conv_err(conv_err)
  );

  ex_branch_ctrl #(.CONV_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .ex_pc(ex_pc), .ex_rB_data(ex_rB_data), .ex_b(ex_b),
    .ex_setcc(ex_setcc), .ex_strd(ex_strd), .ex_conv_en(ex_conv_en), .alu_result(alu_result),
    .conv_done(conv_done), .conv_start(t_conv_start), .stall(t_stall), .b_taken(t_b_taken),
    .b_target(t_b_target), .cc_z(t_cc_z), .cc_n(t_cc_n), .conv_err(t_conv_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rb;
    logic [1:0]  b;
    logic        setcc;
    logic [31:0] alu;
    logic        done;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        exp_z;
    logic        exp_n;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] rb, input logic [1:0] b,
                           input logic setcc, input logic [2:0] strd, input logic conv,
                           input logic [31:0] alu);
    ex_pc = pc; ex_rB_data = rb; ex_b = b; ex_setcc = setcc;
    ex_strd = strd; ex_conv_en = conv; alu_result = alu;
  endtask

  task automatic bubble();
    set_instr(32'd0, 32'd0, 2'b00, 1'b0, 3'd0, 1'b0, 32'd0);
    conv_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bubble();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    int stalls;

    vecs[0] = '{32'h0000_0100, 32'hFFFF_FFF0, 2'b01, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_00F0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0104, 32'h0000_0010, 2'b10, 1'b1, 32'h0,          1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[2] = '{32'h0000_0200, 32'h0000_0040, 2'b10, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0240, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0204, 32'h0000_0040, 2'b11, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[4] = '{32'h0000_0300, 32'h0000_0004, 2'b11, 1'b1, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0304, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0304, 32'h0000_0100, 2'b00, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[6] = '{32'h0,         32'h0,         2'b00, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0008, 2'b01, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0008, 32'h0000_0008, 2'b10, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[9] = '{32'h0000_0010, 32'h0000_0010, 2'b11, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b1};

    bubble();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_b_taken", {31'd0, b_taken}, 32'd0);
    chk("reset_b_target", b_target, 32'd0);
    chk("reset_conv_start", {31'd0, conv_start}, 32'd0);
    chk("reset_cc", {30'd0, cc_z, cc_n}, 32'd0);
    chk("reset_conv_err", {31'd0, conv_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single-cycle instruction table
    for (int i = 0; i < 10; i++) begin
      set_instr(vecs[i].pc, vecs[i].rb, vecs[i].b, vecs[i].setcc, 3'd0, 1'b0, vecs[i].alu);
      conv_done = vecs[i].done;
      @(negedge clk);
      $display("vec %0d: pc=%08h rb=%08h b=%0d setcc=%0d alu=%08h -> taken=%0d target=%08h stall=%0d",
               i, vecs[i].pc, vecs[i].rb, vecs[i].b, vecs[i].setcc, vecs[i].alu, b_taken, b_target, stall);
      chk("vec_stall", {31'd0, stall}, 32'd0);
      chk("vec_conv_start", {31'd0, conv_start}, 32'd0);
      chk("vec_b_taken", {31'd0, b_taken}, {31'd0, vecs[i].exp_taken});
      chk("vec_b_target", b_target, vecs[i].exp_target);
      next_cycle();
      chk("vec_cc", {30'd0, cc_z, cc_n}, {30'd0, vecs[i].exp_z, vecs[i].exp_n});
      chk("vec_conv_err", {31'd0, conv_err}, 32'd0);
    end

    // Reset in the middle of a strided op
    set_instr(32'h0, 32'h0, 2'b00, 1'b1, 3'd0, 1'b0, 32'h0);
    next_cycle();
    chk("pre_rst_cc_z", {31'd0, cc_z}, 32'd1);
    set_instr(32'h50, 32'h4, 2'b00, 1'b0, 3'd5, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("strd5_stall", {31'd0, stall}, 32'd1);
      next_cycle();
    end
    bubble();
    reset = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_cc", {30'd0, cc_z, cc_n}, 32'd0);
    next_cycle();
    reset = 1'b0;
    set_instr(32'h40, 32'h4, 2'b01, 1'b0, 3'd0, 1'b0, 32'h0);
    @(negedge clk);
    $display("post-reset branch: stall=%0d taken=%0d target=%08h", stall, b_taken, b_target);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_taken", {31'd0, b_taken}, 32'd1);
    chk("post_rst_target", b_target, 32'h44);
    next_cycle();

    // ex_strd=3 with an always-branch and setcc: retires on the 4th cycle
    set_instr(32'h400, 32'h10, 2'b01, 1'b1, 3'd3, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      $display("strd3 cycle %0d: stall=%0d taken=%0d target=%08h", i, stall, b_taken, b_target);
      chk("strd3_stall", {31'd0, stall}, {31'd0, (i < 3)});
      chk("strd3_taken", {31'd0, b_taken}, {31'd0, (i == 3)});
      chk("strd3_target", b_target, (i == 3) ? 32'h410 : 32'h0);
      chk("strd3_conv_start", {31'd0, conv_start}, 32'd0);
      next_cycle();
      chk("strd3_cc_z", {31'd0, cc_z}, {31'd0, (i == 3)});
    end
    bubble();

    // Convolution finishing after 10 cycles; conv wins over a simultaneous ex_strd
    set_instr(32'h1000, 32'h20, 2'b01, 1'b0, 3'd3, 1'b1, 32'h0);
    starts = 0;
    stalls = 0;
    for (int i = 0; i <= 10; i++) begin
      conv_done = (i == 10);
      @(negedge clk);
      $display("conv cycle %0d: start=%0d stall=%0d taken=%0d", i, conv_start, stall, b_taken);
      if (conv_start) starts++;
      if (stall) stalls++;
      chk("conv_taken", {31'd0, b_taken}, {31'd0, (i == 10)});
      next_cycle();
    end
    bubble();
    chk("conv_start_pulses", starts, 32'd1);
    chk("conv_stall_cycles", stalls, 32'd10);
    chk("conv_err_clean", {31'd0, conv_err}, 32'd0);
    @(negedge clk);
    chk("conv_after_stall", {31'd0, stall}, 32'd0);
    next_cycle();

    // Timeout with CONV_TIMEOUT=4 and conv_done never asserted
    do_reset();
    set_instr(32'h2000, 32'h0, 2'b00, 1'b0, 3'd0, 1'b1, 32'h0);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      $display("timeout cycle %0d: start=%0d stall=%0d err=%0d", i, t_conv_start, t_stall, t_conv_err);
      chk("to_stall", {31'd0, t_stall}, {31'd0, (i < 4)});
      chk("to_conv_start", {31'd0, t_conv_start}, {31'd0, (i == 0)});
      next_cycle();
    end
    bubble();
    chk("to_conv_err_set", {31'd0, t_conv_err}, 32'd1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("to_conv_err_sticky", {31'd0, t_conv_err}, 32'd1);
    chk("to_idle_stall", {31'd0, t_stall}, 32'd0);
    next_cycle();
    do_reset();
    chk("to_conv_err_cleared", {31'd0, t_conv_err}, 32'd0);

    // conv_done arriving on the timeout cycle: done wins
    set_instr(32'h3000, 32'h0, 2'b00, 1'b0, 3'd0, 1'b1, 32'h0);
    for (int i = 0; i <= 4; i++) begin
      conv_done = (i == 4);
      @(negedge clk);
      chk("tie_stall", {31'd0, t_stall}, {31'd0, (i < 4)});
      next_cycle();
    end
    bubble();
    $display("done/timeout tie: conv_err=%0d", t_conv_err);
    chk("tie_no_err", {31'd0, t_conv_err}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
